// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer state encoding, default region map and error read data.
package apb_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

  localparam int unsigned APB_MAX_WAIT_STATES = 32;

  // Region 0 sits in the least significant ADDR_W slice.
  localparam logic [127:0] APB_REGION_BASE = {
    32'h8c00_0700, 32'h8c00_0600, 32'h8c00_0500, 32'h8c00_0000
  };
  localparam logic [127:0] APB_REGION_LIMIT = {
    32'h8c00_0FFC, 32'h8c00_06FC, 32'h8c00_05FC, 32'h8c00_04FC
  };

  localparam logic [31:0] APB_ERR_PRDATA = '0;

endpackage

// File: rtl/apb_wait_watchdog.sv
// Wait-state counter for one APB transfer; flags when MAX_WAIT wait states have elapsed.
module apb_wait_watchdog
  import apb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = APB_MAX_WAIT_STATES
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clear,
  output logic timeout
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (count_en) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout = (wait_cnt == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/apb_region_decoder.sv
// APB address decoder / response mux with decode-error responses, wait-state
// watchdog and sticky error reporting.
module apb_region_decoder
  import apb_pkg::*;
#(
  parameter int unsigned N_SLAVES  = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_WAIT  = APB_MAX_WAIT_STATES,
  parameter logic [N_SLAVES*ADDR_W-1:0] REGION_BASE  = APB_REGION_BASE,
  parameter logic [N_SLAVES*ADDR_W-1:0] REGION_LIMIT = APB_REGION_LIMIT,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_psel_i,
  input  logic                       m_penable_i,
  input  logic [ADDR_W-1:0]          m_paddr_i,
  output logic [DATA_W-1:0]          m_prdata_o,
  output logic                       m_pready_o,
  output logic                       m_pslverr_o,
  output logic [N_SLAVES-1:0]        s_psel_o,
  input  logic [N_SLAVES*DATA_W-1:0] s_prdata_i,
  input  logic [N_SLAVES-1:0]        s_pready_i,
  input  logic [N_SLAVES-1:0]        s_pslverr_i,
  input  logic                       err_clr_i,
  output logic                       err_irq_o,
  output logic [ERR_CNT_W-1:0]       err_count_o,
  output logic [ADDR_W-1:0]          err_addr_o,
  output logic                       err_timeout_o
);

  localparam int unsigned IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  apb_state_e        state;
  logic [IDX_W-1:0]  idx;
  logic              unmapped;
  logic [ADDR_W-1:0] addr_lat;

  logic              setup;
  logic              dec_hit;
  logic [IDX_W-1:0]  dec_idx;
  logic              done;
  logic              err_evt;
  logic              err_is_to;
  logic              wd_count;
  logic              wd_clear;
  logic              wd_timeout;

  assign setup = m_psel_i & ~m_penable_i;

  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (!dec_hit &&
          m_paddr_i >= REGION_BASE[i*ADDR_W +: ADDR_W] &&
          m_paddr_i <= REGION_LIMIT[i*ADDR_W +: ADDR_W]) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
  end

  // Slave readiness is tested before the watchdog so a slave completing in the
  // last tolerated cycle wins over the forced abort.
  always_comb begin
    s_psel_o    = '0;
    m_prdata_o  = '0;
    m_pready_o  = 1'b0;
    m_pslverr_o = 1'b0;
    done        = 1'b0;
    err_evt     = 1'b0;
    err_is_to   = 1'b0;
    wd_count    = 1'b0;
    wd_clear    = 1'b0;
    case (state)
      IDLE: begin
        if (setup && dec_hit) s_psel_o[dec_idx] = 1'b1;
      end
      ACCESS: begin
        if (!m_psel_i) begin
          wd_clear = 1'b1;
        end else if (unmapped) begin
          m_pready_o  = 1'b1;
          m_pslverr_o = 1'b1;
          m_prdata_o  = DATA_W'(APB_ERR_PRDATA);
          done        = 1'b1;
          err_evt     = 1'b1;
        end else if (s_pready_i[idx]) begin
          s_psel_o[idx] = 1'b1;
          m_pready_o    = 1'b1;
          m_pslverr_o   = s_pslverr_i[idx];
          m_prdata_o    = s_prdata_i[idx*DATA_W +: DATA_W];
          done          = 1'b1;
          wd_clear      = 1'b1;
        end else if (wd_timeout) begin
          m_pready_o  = 1'b1;
          m_pslverr_o = 1'b1;
          m_prdata_o  = DATA_W'(APB_ERR_PRDATA);
          done        = 1'b1;
          err_evt     = 1'b1;
          err_is_to   = 1'b1;
          wd_clear    = 1'b1;
        end else begin
          s_psel_o[idx] = 1'b1;
          wd_count      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      unmapped <= 1'b0;
      addr_lat <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            state    <= ACCESS;
            idx      <= dec_idx;
            unmapped <= ~dec_hit;
            addr_lat <= m_paddr_i;
          end
        end
        ACCESS: begin
          if (!m_psel_i || done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  apb_wait_watchdog #(
    .MAX_WAIT(MAX_WAIT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .count_en(wd_count),
    .clear   (wd_clear),
    .timeout (wd_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_irq_o     <= 1'b0;
      err_count_o   <= '0;
      err_addr_o    <= '0;
      err_timeout_o <= 1'b0;
    end else if (err_evt) begin
      err_irq_o     <= 1'b1;
      err_addr_o    <= addr_lat;
      err_timeout_o <= err_is_to;
      if (err_clr_i) begin
        err_count_o <= ERR_CNT_W'(1);
      end else if (!(&err_count_o)) begin
        err_count_o <= err_count_o + 1'b1;
      end
    end else if (err_clr_i) begin
      err_irq_o   <= 1'b0;
      err_count_o <= '0;
    end
  end

endmodule

// File: tb/tb_apb_region_decoder.sv
// Directed-vector bench for apb_region_decoder; error counter narrowed to 8 bits
// so saturation is reachable in a short run.
module tb_apb_region_decoder;

  localparam int unsigned NS = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;
  logic [NS-1:0] s_psel;
  logic [NS*DW-1:0] s_prdata = '0;
  logic [NS-1:0] s_pready = '0;
  logic [NS-1:0] s_pslverr = '0;
  logic          err_clr = 1'b0;
  logic          err_irq;
  logic [CW-1:0] err_count;
  logic [AW-1:0] err_addr;
  logic          err_timeout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  apb_region_decoder #(
    .N_SLAVES (NS),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_WAIT (32),
    .ERR_CNT_W(CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .m_psel_i     (psel),
    .m_penable_i  (penable),
    .m_paddr_i    (paddr),
    .m_prdata_o   (prdata),
    .m_pready_o   (pready),
    .m_pslverr_o  (pslverr),
    .s_psel_o     (s_psel),
    .s_prdata_i   (s_prdata),
    .s_pready_i   (s_pready),
    .s_pslverr_i  (s_pslverr),
    .err_clr_i    (err_clr),
    .err_irq_o    (err_irq),
    .err_count_o  (err_count),
    .err_addr_o   (err_addr),
    .err_timeout_o(err_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_unmapped(input logic [AW-1:0] a);
    tick(); psel = 1'b1; penable = 1'b0; paddr = a;
    tick(); penable = 1'b1;
    tick(); psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    settle();
    vectors++; if (pready !== 1'b0) begin miscompares++; $display("FAIL reset_pready: got %b exp 0", pready); end
    vectors++; if (pslverr !== 1'b0) begin miscompares++; $display("FAIL reset_pslverr: got %b exp 0", pslverr); end
    vectors++; if (prdata !== '0) begin miscompares++; $display("FAIL reset_prdata: got %h exp 0", prdata); end
    vectors++; if (s_psel !== 4'b0000) begin miscompares++; $display("FAIL reset_s_psel: got %b exp 0000", s_psel); end
    vectors++; if (err_irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b exp 0", err_irq); end
    vectors++; if (err_count !== 8'h00) begin miscompares++; $display("FAIL reset_count: got %h exp 00", err_count); end
    vectors++; if (err_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h exp 0", err_addr); end
    vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b exp 0", err_timeout); end
    tick(); rst = 1'b0;
  endtask

  task automatic test_read_mapped();
    tick(); psel = 1'b1; penable = 1'b0; paddr = 32'h8c00_0010;
    s_pready = 4'b0000; s_prdata[0*DW +: DW] = 32'hA5A5_A5A5;
    settle();
    vectors++; if (s_psel !== 4'b0001) begin miscompares++; $display("FAIL rd_setup_psel: got %b exp 0001", s_psel); end
    tick(); penable = 1'b1;
    settle();
    vectors++; if (pready !== 1'b0) begin miscompares++; $display("FAIL rd_wait_pready: got %b exp 0", pready); end
    tick();
    tick(); s_pready = 4'b0001;
    settle();
    vectors++; if (pready !== 1'b1) begin miscompares++; $display("FAIL rd_pready: got %b exp 1", pready); end
    vectors++; if (prdata !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL rd_prdata: got %h exp a5a5a5a5", prdata); end
    vectors++; if (pslverr !== 1'b0) begin miscompares++; $display("FAIL rd_pslverr: got %b exp 0", pslverr); end
    vectors++; if (s_psel !== 4'b0001) begin miscompares++; $display("FAIL rd_s_psel: got %b exp 0001", s_psel); end
    tick(); psel = 1'b0; penable = 1'b0; s_pready = 4'b0000;
    settle();
    vectors++; if (err_count !== 8'h00) begin miscompares++; $display("FAIL rd_err_count: got %h exp 00", err_count); end
    vectors++; if (pready !== 1'b0) begin miscompares++; $display("FAIL rd_idle_pready: got %b exp 0", pready); end
  endtask

  task automatic test_unmapped();
    tick(); psel = 1'b1; penable = 1'b0; paddr = 32'h8c00_2000;
    settle();
    vectors++; if (s_psel !== 4'b0000) begin miscompares++; $display("FAIL um_setup_psel: got %b exp 0000", s_psel); end
    tick(); penable = 1'b1;
    settle();
    vectors++; if (pready !== 1'b1) begin miscompares++; $display("FAIL um_pready: got %b exp 1", pready); end
    vectors++; if (pslverr !== 1'b1) begin miscompares++; $display("FAIL um_pslverr: got %b exp 1", pslverr); end
    vectors++; if (s_psel !== 4'b0000) begin miscompares++; $display("FAIL um_s_psel: got %b exp 0000", s_psel); end
    vectors++; if (err_irq !== 1'b0) begin miscompares++; $display("FAIL um_irq_early: got %b exp 0", err_irq); end
    tick(); psel = 1'b0; penable = 1'b0;
    settle();
    vectors++; if (err_addr !== 32'h8c00_2000) begin miscompares++; $display("FAIL um_err_addr: got %h exp 8c002000", err_addr); end
    vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL um_err_timeout: got %b exp 0", err_timeout); end
    vectors++; if (err_count !== 8'h01) begin miscompares++; $display("FAIL um_err_count: got %h exp 01", err_count); end
    vectors++; if (err_irq !== 1'b1) begin miscompares++; $display("FAIL um_irq: got %b exp 1", err_irq); end
  endtask

  task automatic test_timeout();
    tick(); psel = 1'b1; penable = 1'b0; paddr = 32'h8c00_0500;
    s_pready = 4'b0000; s_prdata[1*DW +: DW] = 32'hDEAD_BEEF;
    tick(); penable = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      settle();
      if (k == 32) begin
        vectors++; if (pready !== 1'b0) begin miscompares++; $display("FAIL to_c32_pready: got %b exp 0", pready); end
        vectors++; if (s_psel !== 4'b0010) begin miscompares++; $display("FAIL to_c32_psel: got %b exp 0010", s_psel); end
      end
      if (k == 33) begin
        vectors++; if (pready !== 1'b1) begin miscompares++; $display("FAIL to_c33_pready: got %b exp 1", pready); end
        vectors++; if (pslverr !== 1'b1) begin miscompares++; $display("FAIL to_c33_pslverr: got %b exp 1", pslverr); end
        vectors++; if (prdata !== 32'h0) begin miscompares++; $display("FAIL to_c33_prdata: got %h exp 0", prdata); end
        vectors++; if (s_psel !== 4'b0000) begin miscompares++; $display("FAIL to_c33_psel: got %b exp 0000", s_psel); end
      end
      tick();
    end
    psel = 1'b0; penable = 1'b0;
    settle();
    vectors++; if (err_timeout !== 1'b1) begin miscompares++; $display("FAIL to_err_timeout: got %b exp 1", err_timeout); end
    vectors++; if (err_addr !== 32'h8c00_0500) begin miscompares++; $display("FAIL to_err_addr: got %h exp 8c000500", err_addr); end
    vectors++; if (err_count !== 8'h02) begin miscompares++; $display("FAIL to_err_count: got %h exp 02", err_count); end
  endtask

  task automatic test_ready_at_limit();
    tick(); psel = 1'b1; penable = 1'b0; paddr = 32'h8c00_0504;
    s_pready = 4'b0000; s_prdata[1*DW +: DW] = 32'h1234_5678;
    tick(); penable = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      if (k == 33) s_pready = 4'b0010;
      settle();
      if (k == 33) begin
        vectors++; if (pready !== 1'b1) begin miscompares++; $display("FAIL lim_pready: got %b exp 1", pready); end
        vectors++; if (pslverr !== 1'b0) begin miscompares++; $display("FAIL lim_pslverr: got %b exp 0", pslverr); end
        vectors++; if (prdata !== 32'h1234_5678) begin miscompares++; $display("FAIL lim_prdata: got %h exp 12345678", prdata); end
        vectors++; if (s_psel !== 4'b0010) begin miscompares++; $display("FAIL lim_psel: got %b exp 0010", s_psel); end
      end
      tick();
    end
    psel = 1'b0; penable = 1'b0; s_pready = 4'b0000;
    settle();
    vectors++; if (err_count !== 8'h02) begin miscompares++; $display("FAIL lim_err_count: got %h exp 02", err_count); end
    vectors++; if (err_addr !== 32'h8c00_0500) begin miscompares++; $display("FAIL lim_err_addr: got %h exp 8c000500", err_addr); end
  endtask

  task automatic test_saturation();
    tick(); err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    settle();
    vectors++; if (err_count !== 8'h00) begin miscompares++; $display("FAIL clr_count: got %h exp 00", err_count); end
    vectors++; if (err_irq !== 1'b0) begin miscompares++; $display("FAIL clr_irq: got %b exp 0", err_irq); end
    vectors++; if (err_addr !== 32'h8c00_0500) begin miscompares++; $display("FAIL clr_addr_kept: got %h exp 8c000500", err_addr); end
    for (int n = 0; n < 257; n++) do_unmapped(32'h9000_0000 + 32'(n));
    settle();
    vectors++; if (err_count !== 8'hFF) begin miscompares++; $display("FAIL sat_count: got %h exp ff", err_count); end
    vectors++; if (err_addr !== 32'h9000_0100) begin miscompares++; $display("FAIL sat_addr: got %h exp 90000100", err_addr); end
    tick(); psel = 1'b1; penable = 1'b0; paddr = 32'h8c00_3000;
    tick(); penable = 1'b1; err_clr = 1'b1;
    tick(); psel = 1'b0; penable = 1'b0; err_clr = 1'b0;
    settle();
    vectors++; if (err_count !== 8'h01) begin miscompares++; $display("FAIL clr_err_count: got %h exp 01", err_count); end
    vectors++; if (err_irq !== 1'b1) begin miscompares++; $display("FAIL clr_err_irq: got %b exp 1", err_irq); end
    vectors++; if (err_addr !== 32'h8c00_3000) begin miscompares++; $display("FAIL clr_err_addr: got %h exp 8c003000", err_addr); end
  endtask

  task automatic test_psel_drop();
    tick(); psel = 1'b1; penable = 1'b0; paddr = 32'h8c00_0700; s_pready = 4'b0000;
    tick(); penable = 1'b1;
    tick();
    tick(); psel = 1'b0; penable = 1'b0;
    settle();
    vectors++; if (pready !== 1'b0) begin miscompares++; $display("FAIL drop_pready: got %b exp 0", pready); end
    vectors++; if (s_psel !== 4'b0000) begin miscompares++; $display("FAIL drop_psel: got %b exp 0000", s_psel); end
    tick(); tick();
    settle();
    vectors++; if (err_count !== 8'h01) begin miscompares++; $display("FAIL drop_err_count: got %h exp 01", err_count); end
  endtask

  task automatic test_back_to_back();
    tick(); psel = 1'b1; penable = 1'b0; paddr = 32'h8c00_0800;
    s_pready = 4'b1000; s_prdata[3*DW +: DW] = 32'h3333_3333;
    settle();
    vectors++; if (s_psel !== 4'b1000) begin miscompares++; $display("FAIL b2b_setup0_psel: got %b exp 1000", s_psel); end
    tick(); penable = 1'b1;
    settle();
    vectors++; if (prdata !== 32'h3333_3333) begin miscompares++; $display("FAIL b2b_prdata0: got %h exp 33333333", prdata); end
    vectors++; if (pready !== 1'b1) begin miscompares++; $display("FAIL b2b_pready0: got %b exp 1", pready); end
    tick(); penable = 1'b0; paddr = 32'h8c00_0604;
    s_pready = 4'b0100; s_pslverr = 4'b0100; s_prdata[2*DW +: DW] = 32'h2222_2222;
    settle();
    vectors++; if (s_psel !== 4'b0100) begin miscompares++; $display("FAIL b2b_setup1_psel: got %b exp 0100", s_psel); end
    vectors++; if (pready !== 1'b0) begin miscompares++; $display("FAIL b2b_setup1_pready: got %b exp 0", pready); end
    tick(); penable = 1'b1;
    settle();
    vectors++; if (prdata !== 32'h2222_2222) begin miscompares++; $display("FAIL b2b_prdata1: got %h exp 22222222", prdata); end
    vectors++; if (pslverr !== 1'b1) begin miscompares++; $display("FAIL b2b_pslverr1: got %b exp 1", pslverr); end
    tick(); psel = 1'b0; penable = 1'b0; s_pready = 4'b0000; s_pslverr = 4'b0000;
    settle();
    vectors++; if (err_count !== 8'h01) begin miscompares++; $display("FAIL b2b_err_count: got %h exp 01", err_count); end
  endtask

  task automatic test_reset_midwait();
    tick(); psel = 1'b1; penable = 1'b0; paddr = 32'h8c00_0600; s_pready = 4'b0000;
    tick(); penable = 1'b1;
    tick();
    tick(); rst = 1'b1;
    #1;
    vectors++; if (s_psel !== 4'b0000) begin miscompares++; $display("FAIL rstw_psel: got %b exp 0000", s_psel); end
    vectors++; if (pready !== 1'b0) begin miscompares++; $display("FAIL rstw_pready: got %b exp 0", pready); end
    vectors++; if (err_count !== 8'h00) begin miscompares++; $display("FAIL rstw_count: got %h exp 00", err_count); end
    vectors++; if (err_irq !== 1'b0) begin miscompares++; $display("FAIL rstw_irq: got %b exp 0", err_irq); end
    vectors++; if (err_addr !== 32'h0) begin miscompares++; $display("FAIL rstw_addr: got %h exp 0", err_addr); end
    tick(); psel = 1'b0; penable = 1'b0;
    tick(); rst = 1'b0;
    tick(); psel = 1'b1; penable = 1'b0; paddr = 32'h8c00_0600;
    s_pready = 4'b0100; s_prdata[2*DW +: DW] = 32'h600D_F00D;
    settle();
    vectors++; if (s_psel !== 4'b0100) begin miscompares++; $display("FAIL rstw_setup_psel: got %b exp 0100", s_psel); end
    tick(); penable = 1'b1;
    settle();
    vectors++; if (prdata !== 32'h600D_F00D) begin miscompares++; $display("FAIL rstw_prdata: got %h exp 600df00d", prdata); end
    vectors++; if (pready !== 1'b1) begin miscompares++; $display("FAIL rstw_pready2: got %b exp 1", pready); end
    vectors++; if (pslverr !== 1'b0) begin miscompares++; $display("FAIL rstw_pslverr: got %b exp 0", pslverr); end
    tick(); psel = 1'b0; penable = 1'b0; s_pready = 4'b0000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete, exp finish before 1000000 ns");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_mapped();
    test_unmapped();
    test_timeout();
    test_ready_at_limit();
    test_saturation();
    test_psel_drop();
    test_back_to_back();
    test_reset_midwait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
